multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Control FSM for the 24-bit multicycle processor datapath. It sequences every instruction through IF, ID, EXEC, MEM and WB, and decodes the IR fields: opcode IR[21:17], SF bit IR[16] and condition IR[23:22]. From these it drives the datapath write enables, mux selects and ALU operation. It also exports the state encoding and instruction/cycle counters used by the datapath bench for per-stage display and CPI reporting.

## Interface
- `PC_STEP`, 3: increment applied by the datapath on the sequential PC path; documented only, no logic depends on it.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ir`  in  24  current instruction register.
- `zFlag`  in  1  registered Z flag, used for conditional execution.
- `ALUzero`  in  1  ALU zero output, used for BEQ.
- `mem_ready`  in  1  memory completion handshake.
- `currState`  out  3  current state: IF=000, ID=001, EXEC=010, MEM=011, WB=100.
- `NextState`  out  3  combinational next state.
- `IRwrite`, `pcWrite`, `regWr`, `memRd`, `memWr`, `flagWr`  out  1 each  write enables.
- `pcSrc`  out  2  PC select: 00 = PC+3, 01 = jump target, 10 = JR register, 11 = branch target.
- `ALUop`  out  3  000 = AND, 001 = ADD/SUB, 010 = MAX, 011 = CMP, 100 = SHIFT.
- `ALUsrcImm`, `subOp`, `wbSrc`  out  1 each  ALU B-input select, subtract select, WB data select (0 = ALU, 1 = memory).
- `illegal`  out  1  pulses in ID for opcodes 16–31 and condition 11.
- `insNum`, `cycCnt`, `lastCPI`  out  `CNT_W` each  performance counters.

## Operation
- `currState` is the only state register. All controls are combinational from `currState` and `ir`.
- IF: assert `IRwrite` and `memRd`; go to ID.
- ID condition check:
  - If cond=01 and zFlag=0, or cond=10 and zFlag=1, the instruction is skipped: `pcWrite`=1, `pcSrc`=00, go to IF.
  - If cond=11 or opcode ≥ 16: assert `illegal` and skip the same way.
- Instruction paths:
  - AND, CAS, ADD, SUB, CMP, ANDI, ADDI, SUBI: IF→ID→EXEC→WB.
    - `ALUsrcImm`=1 for the immediate forms.
    - `subOp`=1 for SUB and SUBI.
    - ALUop: CAS=010, CMP=011.
  - LW, LWS: IF→ID→EXEC→MEM→WB, with `wbSrc`=1.
  - SW: IF→ID→EXEC→MEM.
  - BEQ: IF→ID→EXEC, with `ALUop`=001 and `subOp`=1.
  - J, JR: IF→ID, with `pcSrc`=01 and 10 respectively.
  - JAL: IF→ID→WB. In ID: `pcWrite`, `pcSrc`=01. WB writes the return address into R7.
  - LUI: IF→ID→WB.
- `pcWrite` is asserted only in the final state of each instruction:
  - `pcSrc`=00, except jumps (as above).
  - BEQ with `ALUzero`=1 uses `pcSrc`=11.
- `flagWr`=1 in EXEC when SF=1 for ALU-class instructions. It is never asserted for loads, stores or branches.
- MEM holds `memRd` or `memWr` until `mem_ready`=1, then advances. `memWr` must stay high for every cycle spent in MEM.
- `regWr` is asserted only in WB. WB always returns to IF.

## Timing
- Reset (asynchronous, `reset`=0):
  - `currState`=IF.
  - All counters 0.
  - All enables 0, except IF decode (`IRwrite`, `memRd`), which is asserted while in IF.
- Reset deasserted mid-instruction: the aborted instruction is not counted, and no `pcWrite` occurs for it.
- Cycles per instruction with `mem_ready` tied high:
  - 2: skipped, illegal, J, JR.
  - 3: BEQ, JAL, LUI.
  - 4: ALU class, SW.
  - 5: loads.
- Each cycle of low `mem_ready` adds one cycle.
- Counters:
  - `insNum` increments on each ID→next transition.
  - `cycCnt` increments every cycle.
  - `lastCPI` loads the cycle count of the completed instruction when re-entering IF.
- All counters wrap at 2^`CNT_W`.

## Configuration
- `CTRL_PERF_COUNT_EN` defined: `insNum`, `cycCnt` and `lastCPI` are implemented as described.
- Not defined: the counter registers are removed and all three outputs are constant 0. FSM behaviour is unchanged.

## Test plan
- Reset with `reset`=0 asserted mid-EXEC → `currState`=000 immediately (no clock edge needed) and counters 0.
  - After release: IR=ADD R1,R2,R3 → states 000,001,010,100,000; `regWr` only in 100; `lastCPI`=4.
- LW with `mem_ready` low for 3 cycles → MEM held for 4 cycles with `memRd`=1; `lastCPI`=8; `wbSrc`=1 in WB.
- BEQ with `ALUzero`=1 → EXEC has `pcWrite`=1, `pcSrc`=11, then IF.
  - With `ALUzero`=0: `pcSrc`=00; `lastCPI`=3.
- ADD EQ with zFlag=0 → ID has `pcWrite`=1 and `pcSrc`=00, then IF; `lastCPI`=2; `regWr` never asserted.
- Opcode 10110 → `illegal` pulse in ID, return to IF; `insNum` increments.
  - JAL → `pcSrc`=01 in ID, then WB with `regWr`=1.
- ADDI with SF=1 → `flagWr`=1 only in EXEC.
  - Rebuild without `CTRL_PERF_COUNT_EN` → all three counter outputs stay 0.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if
// Bundles the signals between the multicycle datapath and its control FSM.
//   master : datapath side (drives ir, zFlag, ALUzero, mem_ready; reads controls)
//   slave  : control unit side (reads datapath status; drives controls, state, counters)
// Parameter CNT_W sets the width of the performance counter signals.
interface multicycle_control_unit_if #(
  parameter int CNT_W = 16
);
  logic [23:0]      ir;
  logic             zFlag;
  logic             ALUzero;
  logic             mem_ready;

  logic [2:0]       currState;
  logic [2:0]       NextState;
  logic             IRwrite;
  logic             pcWrite;
  logic             regWr;
  logic             memRd;
  logic             memWr;
  logic             flagWr;
  logic [1:0]       pcSrc;
  logic [2:0]       ALUop;
  logic             ALUsrcImm;
  logic             subOp;
  logic             wbSrc;
  logic             illegal;
  logic [CNT_W-1:0] insNum;
  logic [CNT_W-1:0] cycCnt;
  logic [CNT_W-1:0] lastCPI;

  modport master (
    output ir, zFlag, ALUzero, mem_ready,
    input  currState, NextState, IRwrite, pcWrite, regWr, memRd, memWr, flagWr,
           pcSrc, ALUop, ALUsrcImm, subOp, wbSrc, illegal, insNum, cycCnt, lastCPI
  );

  modport slave (
    input  ir, zFlag, ALUzero, mem_ready,
    output currState, NextState, IRwrite, pcWrite, regWr, memRd, memWr, flagWr,
           pcSrc, ALUop, ALUsrcImm, subOp, wbSrc, illegal, insNum, cycCnt, lastCPI
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Control FSM for the 24-bit multicycle datapath. Sequences IF, ID, EXEC, MEM, WB
// and decodes ir: cond = ir[23:22], opcode = ir[21:17], SF = ir[16].
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : multicycle_control_unit_if.slave (ir/flags/mem_ready in; controls,
//           state, performance counters out)
// Parameters:
//   PC_STEP : sequential PC increment used by the datapath (informational)
//   CNT_W   : performance counter width
// Build option:
//   CTRL_PERF_COUNT_EN defined   -> insNum, cycCnt, lastCPI implemented
//   CTRL_PERF_COUNT_EN undefined -> the three counter outputs are constant 0
//
// Opcode map: AND=0 CAS=1 ADD=2 SUB=3 CMP=4 ANDI=5 ADDI=6 SUBI=7 LW=8 LWS=9
//             SW=10 BEQ=11 J=12 JR=13 JAL=14 LUI=15; 16..31 illegal.
// Condition:  00 always, 01 execute if Z=1, 10 execute if Z=0, 11 illegal.
//
// state | meaning
// IF    | fetch: IRwrite, memRd
// ID    | decode, condition check, jumps / skips complete here
// EXEC  | ALU operation, BEQ resolves here
// MEM   | load/store, held until mem_ready
// WB    | register write-back, always returns to IF
module multicycle_control_unit #(
  parameter int PC_STEP = 3,
  parameter int CNT_W   = 16
) (
  input logic                        clk,
  input logic                        reset,
  multicycle_control_unit_if.slave   bus
);

  if (PC_STEP <= 0) begin : g_pc_step_check
    $error("PC_STEP must be positive");
  end

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXEC = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100
  } state_t;

  localparam logic [4:0] OP_AND  = 5'd0;
  localparam logic [4:0] OP_CAS  = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_CMP  = 5'd4;
  localparam logic [4:0] OP_ANDI = 5'd5;
  localparam logic [4:0] OP_ADDI = 5'd6;
  localparam logic [4:0] OP_SUBI = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;
  localparam logic [4:0] OP_LWS  = 5'd9;
  localparam logic [4:0] OP_SW   = 5'd10;
  localparam logic [4:0] OP_BEQ  = 5'd11;
  localparam logic [4:0] OP_J    = 5'd12;
  localparam logic [4:0] OP_JR   = 5'd13;
  localparam logic [4:0] OP_JAL  = 5'd14;
  localparam logic [4:0] OP_LUI  = 5'd15;

  state_t state, next_state;

  logic [1:0] cond;
  logic [4:0] opcode;
  logic       sf;
  logic       is_load;
  logic       cond_fail;

  logic       ir_write, pc_write, reg_wr, mem_rd, mem_wr, flag_wr;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  logic       alu_src_imm, sub_op, wb_src, illegal_op;

  assign cond      = bus.ir[23:22];
  assign opcode    = bus.ir[21:17];
  assign sf        = bus.ir[16];
  assign is_load   = (opcode == OP_LW) || (opcode == OP_LWS);
  assign cond_fail = ((cond == 2'b01) && !bus.zFlag) || ((cond == 2'b10) && bus.zFlag);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IF;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    flag_wr     = 1'b0;
    pc_src      = 2'b00;
    alu_op      = 3'b000;
    alu_src_imm = 1'b0;
    sub_op      = 1'b0;
    wb_src      = 1'b0;
    illegal_op  = 1'b0;

    case (state)
      S_IF: begin
        ir_write   = 1'b1;
        mem_rd     = 1'b1;
        next_state = S_ID;
      end

      S_ID: begin
        // Illegal takes priority so cond=11 is flagged regardless of Z.
        if ((cond == 2'b11) || opcode[4]) begin
          illegal_op = 1'b1;
          pc_write   = 1'b1;
          next_state = S_IF;
        end else if (cond_fail) begin
          pc_write   = 1'b1;
          next_state = S_IF;
        end else begin
          case (opcode)
            OP_J: begin
              pc_write   = 1'b1;
              pc_src     = 2'b01;
              next_state = S_IF;
            end
            OP_JR: begin
              pc_write   = 1'b1;
              pc_src     = 2'b10;
              next_state = S_IF;
            end
            OP_JAL: begin
              // PC moves to the target here; WB only stores the return address.
              pc_write   = 1'b1;
              pc_src     = 2'b01;
              next_state = S_WB;
            end
            OP_LUI:  next_state = S_WB;
            default: next_state = S_EXEC;
          endcase
        end
      end

      S_EXEC: begin
        case (opcode)
          OP_AND, OP_ANDI, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_CAS, OP_CMP: begin
            case (opcode)
              OP_AND, OP_ANDI: alu_op = 3'b000;
              OP_CAS:          alu_op = 3'b010;
              OP_CMP:          alu_op = 3'b011;
              default:         alu_op = 3'b001;
            endcase
            alu_src_imm = (opcode == OP_ANDI) || (opcode == OP_ADDI) || (opcode == OP_SUBI);
            sub_op      = (opcode == OP_SUB) || (opcode == OP_SUBI);
            flag_wr     = sf;
            next_state  = S_WB;
          end
          OP_LW, OP_LWS, OP_SW: begin
            // Address = base + immediate.
            alu_op      = 3'b001;
            alu_src_imm = 1'b1;
            next_state  = S_MEM;
          end
          OP_BEQ: begin
            alu_op     = 3'b001;
            sub_op     = 1'b1;
            pc_write   = 1'b1;
            pc_src     = bus.ALUzero ? 2'b11 : 2'b00;
            next_state = S_IF;
          end
          default: next_state = S_IF;
        endcase
      end

      S_MEM: begin
        mem_rd = is_load;
        mem_wr = !is_load;
        if (bus.mem_ready) begin
          if (is_load) begin
            next_state = S_WB;
          end else begin
            pc_write   = 1'b1;
            next_state = S_IF;
          end
        end
      end

      S_WB: begin
        reg_wr     = 1'b1;
        wb_src     = is_load;
        pc_write   = (opcode != OP_JAL);
        next_state = S_IF;
      end

      default: next_state = S_IF;
    endcase
  end

  assign bus.currState = state;
  assign bus.NextState = next_state;
  assign bus.IRwrite   = ir_write;
  assign bus.pcWrite   = pc_write;
  assign bus.regWr     = reg_wr;
  assign bus.memRd     = mem_rd;
  assign bus.memWr     = mem_wr;
  assign bus.flagWr    = flag_wr;
  assign bus.pcSrc     = pc_src;
  assign bus.ALUop     = alu_op;
  assign bus.ALUsrcImm = alu_src_imm;
  assign bus.subOp     = sub_op;
  assign bus.wbSrc     = wb_src;
  assign bus.illegal   = illegal_op;

`ifdef CTRL_PERF_COUNT_EN
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] ins_cnt, cyc_cnt, cpi_q, ins_cyc;

  // ins_cyc counts cycles of the instruction in flight; it is captured into
  // lastCPI on the edge that re-enters IF.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ins_cnt <= '0;
      cyc_cnt <= '0;
      cpi_q   <= '0;
      ins_cyc <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + ONE;
      if (state == S_ID) begin
        ins_cnt <= ins_cnt + ONE;
      end
      if ((next_state == S_IF) && (state != S_IF)) begin
        cpi_q   <= ins_cyc + ONE;
        ins_cyc <= '0;
      end else begin
        ins_cyc <= ins_cyc + ONE;
      end
    end
  end

  assign bus.insNum  = ins_cnt;
  assign bus.cycCnt  = cyc_cnt;
  assign bus.lastCPI = cpi_q;
`else
  assign bus.insNum  = '0;
  assign bus.cycCnt  = '0;
  assign bus.lastCPI = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
  localparam int CNT_W = 16;

  localparam logic [2:0] IF_S = 3'd0, ID_S = 3'd1, EX_S = 3'd2, MEM_S = 3'd3, WB_S = 3'd4;

  localparam logic [4:0] AND_O = 5'd0, CAS_O = 5'd1, ADD_O = 5'd2, SUB_O = 5'd3, CMP_O = 5'd4,
                         ANDI_O = 5'd5, ADDI_O = 5'd6, SUBI_O = 5'd7, LW_O = 5'd8, LWS_O = 5'd9,
                         SW_O = 5'd10, BEQ_O = 5'd11, J_O = 5'd12, JR_O = 5'd13, JAL_O = 5'd14,
                         LUI_O = 5'd15;

  logic clk = 1'b0;
  logic reset;

  multicycle_control_unit_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control_unit #(.PC_STEP(3), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected values for the current cycle, compared on the falling edge.
  bit         chk_on = 1'b0;
  logic [2:0] e_st, e_nx, e_aluop;
  logic [1:0] e_pcsrc;
  logic [9:0] e_en;   // {IRwrite,pcWrite,regWr,memRd,memWr,flagWr,ALUsrcImm,subOp,wbSrc,illegal}
  logic [CNT_W-1:0] e_ins, e_cyc, e_cpi;

  // Model counters (abstract: plain integers)
  int m_cyc = 0, m_ins = 0, m_cpi = 0;

  wire [9:0] a_en = {bus.IRwrite, bus.pcWrite, bus.regWr, bus.memRd, bus.memWr,
                     bus.flagWr, bus.ALUsrcImm, bus.subOp, bus.wbSrc, bus.illegal};

  function automatic logic [31:0] pf(input int v);
`ifdef CTRL_PERF_COUNT_EN
    logic [31:0] t;
    t = v;
    return {16'h0, t[CNT_W-1:0]};
`else
    return (v < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("currState", {29'd0, bus.currState}, {29'd0, e_st});
      check("NextState", {29'd0, bus.NextState}, {29'd0, e_nx});
      check("enables",   {22'd0, a_en},          {22'd0, e_en});
      check("pcSrc",     {30'd0, bus.pcSrc},     {30'd0, e_pcsrc});
      check("ALUop",     {29'd0, bus.ALUop},     {29'd0, e_aluop});
      check("insNum",    {16'd0, bus.insNum},    {16'd0, e_ins});
      check("cycCnt",    {16'd0, bus.cycCnt},    {16'd0, e_cyc});
      check("lastCPI",   {16'd0, bus.lastCPI},   {16'd0, e_cpi});
    end
  end

  function automatic logic [23:0] mk(input logic [1:0] c, input logic [4:0] op, input logic s);
    return {c, op, s, 16'h2A5C};
  endfunction

  // Runs one instruction from IF. stop_after > 0 leaves it after that many cycles.
  task automatic run_ins(input logic [23:0] irv, input logic z, input logic az,
                         input int wait_n, input int stop_after);
    logic [2:0] seq[$];
    logic [1:0] c;
    logic [4:0] op;
    logic       s, ill, skp, ld;
    int total, lim, memk;
    c  = irv[23:22];
    op = irv[21:17];
    s  = irv[16];
    ill = (c == 2'b11) || (op >= 5'd16);
    skp = !ill && (((c == 2'b01) && !z) || ((c == 2'b10) && z));
    ld  = (op == LW_O) || (op == LWS_O);
    seq = '{IF_S, ID_S};
    if (!ill && !skp) begin
      if (op == BEQ_O) seq.push_back(EX_S);
      else if (op == JAL_O || op == LUI_O) seq.push_back(WB_S);
      else if (op == J_O || op == JR_O) begin end
      else if (op == SW_O || ld) begin
        seq.push_back(EX_S);
        for (int i = 0; i <= wait_n; i++) seq.push_back(MEM_S);
        if (ld) seq.push_back(WB_S);
      end else begin
        seq.push_back(EX_S);
        seq.push_back(WB_S);
      end
    end
    total = seq.size();
    lim   = (stop_after > 0) ? stop_after : total;
    memk  = 0;
    for (int k = 0; k < lim; k++) begin
      logic last;
      last = (k == total - 1);
      bus.ir      = irv;
      bus.zFlag   = z;
      bus.ALUzero = az;
      bus.mem_ready = (seq[k] == MEM_S) ? (memk >= wait_n) : 1'b0;
      e_st    = seq[k];
      e_nx    = last ? IF_S : seq[k+1];
      e_en    = '0;
      e_pcsrc = 2'b00;
      e_aluop = 3'b000;
      case (seq[k])
        IF_S: begin e_en[9] = 1; e_en[6] = 1; end
        ID_S: begin
          if (ill) begin e_en[0] = 1; e_en[8] = 1; end
          else if (skp) e_en[8] = 1;
          else if (op == J_O || op == JAL_O) begin e_en[8] = 1; e_pcsrc = 2'b01; end
          else if (op == JR_O) begin e_en[8] = 1; e_pcsrc = 2'b10; end
        end
        EX_S: begin
          if (op == BEQ_O) begin
            e_aluop = 3'b001; e_en[2] = 1; e_en[8] = 1; e_pcsrc = az ? 2'b11 : 2'b00;
          end else if (op == SW_O || ld) begin
            e_aluop = 3'b001; e_en[3] = 1;
          end else begin
            e_aluop = (op == AND_O || op == ANDI_O) ? 3'b000 :
                      (op == CAS_O) ? 3'b010 : (op == CMP_O) ? 3'b011 : 3'b001;
            e_en[3] = (op == ANDI_O || op == ADDI_O || op == SUBI_O);
            e_en[2] = (op == SUB_O || op == SUBI_O);
            e_en[4] = s;
          end
        end
        MEM_S: begin
          if (ld) e_en[6] = 1; else e_en[5] = 1;
          if (!ld && last) e_en[8] = 1;
          memk++;
        end
        default: begin
          e_en[7] = 1;
          e_en[1] = ld;
          e_en[8] = (op != JAL_O);
        end
      endcase
      e_cyc  = pf(m_cyc)[CNT_W-1:0];
      e_ins  = pf(m_ins)[CNT_W-1:0];
      e_cpi  = pf(m_cpi)[CNT_W-1:0];
      chk_on = 1'b1;
      @(posedge clk);
      #1;
      m_cyc++;
      if (seq[k] == ID_S) m_ins++;
    end
    if (lim == total) m_cpi = total;
  endtask

  initial begin
    reset = 1'b0;
    bus.ir = mk(2'b00, ADD_O, 1'b0);
    bus.zFlag = 1'b0; bus.ALUzero = 1'b0; bus.mem_ready = 1'b0;
    #1;
    check("rst_state",   {29'd0, bus.currState}, 32'd0);
    check("rst_irwrite", {31'd0, bus.IRwrite},   32'd1);
    check("rst_pcwrite", {31'd0, bus.pcWrite},   32'd0);
    check("rst_cyccnt",  {16'd0, bus.cycCnt},    32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_ins(mk(2'b00, ADD_O, 1'b0), 1'b0, 1'b0, 0, 0);
    check("cpi_add0", {16'd0, bus.lastCPI}, pf(4));

    // Abort an ADD in EXEC with an asynchronous reset.
    run_ins(mk(2'b00, ADD_O, 1'b0), 1'b0, 1'b0, 0, 2);
    chk_on = 1'b0;
    check("abort_in_exec", {29'd0, bus.currState}, 32'd2);
    #2 reset = 1'b0;
    #1;
    check("async_rst_state", {29'd0, bus.currState}, 32'd0);
    check("async_rst_ins",   {16'd0, bus.insNum},    32'd0);
    check("async_rst_cyc",   {16'd0, bus.cycCnt},    32'd0);
    check("async_rst_cpi",   {16'd0, bus.lastCPI},   32'd0);
    check("async_rst_pcw",   {31'd0, bus.pcWrite},   32'd0);
    m_cyc = 0; m_ins = 0; m_cpi = 0;
    @(posedge clk); #1;
    reset = 1'b1;

    run_ins(mk(2'b00, ADD_O, 1'b0), 1'b0, 1'b0, 0, 0);
    check("cpi_add", {16'd0, bus.lastCPI}, pf(4));
    run_ins(mk(2'b00, LW_O, 1'b0), 1'b0, 1'b0, 3, 0);
    check("cpi_lw_wait3", {16'd0, bus.lastCPI}, pf(8));
    run_ins(mk(2'b00, BEQ_O, 1'b0), 1'b0, 1'b1, 0, 0);
    run_ins(mk(2'b00, BEQ_O, 1'b0), 1'b0, 1'b0, 0, 0);
    check("cpi_beq", {16'd0, bus.lastCPI}, pf(3));
    run_ins(mk(2'b01, ADD_O, 1'b0), 1'b0, 1'b0, 0, 0);
    check("cpi_skip", {16'd0, bus.lastCPI}, pf(2));
    run_ins(mk(2'b10, ADD_O, 1'b0), 1'b1, 1'b0, 0, 0);
    run_ins(mk(2'b01, ADD_O, 1'b0), 1'b1, 1'b0, 0, 0);
    run_ins(mk(2'b00, 5'b10110, 1'b0), 1'b0, 1'b0, 0, 0);
    check("ins_after_illegal", {16'd0, bus.insNum}, pf(8));
    run_ins(mk(2'b11, ADD_O, 1'b0), 1'b1, 1'b0, 0, 0);
    run_ins(mk(2'b00, JAL_O, 1'b0), 1'b0, 1'b0, 0, 0);
    check("cpi_jal", {16'd0, bus.lastCPI}, pf(3));
    run_ins(mk(2'b00, J_O, 1'b0), 1'b0, 1'b0, 0, 0);
    run_ins(mk(2'b00, JR_O, 1'b0), 1'b0, 1'b0, 0, 0);
    run_ins(mk(2'b00, LUI_O, 1'b0), 1'b0, 1'b0, 0, 0);
    run_ins(mk(2'b00, SW_O, 1'b0), 1'b0, 1'b0, 2, 0);
    check("cpi_sw_wait2", {16'd0, bus.lastCPI}, pf(6));
    run_ins(mk(2'b00, LWS_O, 1'b0), 1'b0, 1'b0, 0, 0);
    run_ins(mk(2'b00, ADDI_O, 1'b1), 1'b0, 1'b0, 0, 0);
    run_ins(mk(2'b00, SUBI_O, 1'b0), 1'b0, 1'b0, 0, 0);
    run_ins(mk(2'b00, SUB_O, 1'b1), 1'b0, 1'b0, 0, 0);
    run_ins(mk(2'b00, CAS_O, 1'b0), 1'b0, 1'b0, 0, 0);
    run_ins(mk(2'b00, CMP_O, 1'b1), 1'b0, 1'b0, 0, 0);
    run_ins(mk(2'b00, AND_O, 1'b0), 1'b0, 1'b0, 0, 0);
    run_ins(mk(2'b00, ANDI_O, 1'b1), 1'b0, 1'b0, 0, 0);
    run_ins(mk(2'b00, LW_O, 1'b0), 1'b0, 1'b0, 0, 0);
    check("cpi_lw", {16'd0, bus.lastCPI}, pf(5));
    check("final_cyc", {16'd0, bus.cycCnt}, pf(m_cyc));
    check("final_ins", {16'd0, bus.insNum}, pf(m_ins));
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
